// File: rtl/sram_arbiter.sv
// sram_arbiter: owns the single SRAM port and shares it between three users.
// Priority order: the clear engine, the VGA scanout reader, then the pixel writer.
// The framebuffer is cleared after reset and again on every start_clear.
// VGA reads always return after READ_LAT cycles, even while a clear is running.
// Optional build macro SRAM_ARB_STALL_CNT_EN adds a saturating stall counter
// for the writer. Without it, stall_cnt is tied to zero.
module sram_arbiter #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 16,
  parameter int                CLEAR_TOP   = 416800,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter int                READ_LAT    = 2      // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_clear,
  output logic              clear_busy,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_TOP - 1);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;

  logic in_run;
  logic flush;
  logic vga_grant;
  logic wr_grant;
  logic last_vld;
  logic last_zero;

  // A start_clear seen in RUN wins over both users for that edge.
  // Reads still in flight at that point return zero data.
  assign in_run    = (state_reg == ST_RUN);
  assign flush     = in_run && start_clear;
  assign vga_grant = in_run && !start_clear && vga_req;
  // A write cannot be granted on the edge after an ack.
  // So a level request that is still held is never written twice.
  assign wr_grant  = in_run && !start_clear && !vga_req && wr_req && !wr_ack;

  // Clear sequencing, grant selection and the registered SRAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_d       <= '0;
      wr_ack      <= 1'b0;
      clear_busy  <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          mem_wren    <= 1'b1;
          mem_addr    <= clr_cnt_reg;
          mem_d       <= CLEAR_VALUE;
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          wr_ack      <= 1'b0;
          clear_busy  <= 1'b1;
          if (clr_cnt_reg == CLR_LAST) begin
            state_reg <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          // One turnaround cycle so the last clear write is not followed
          // directly by a read on the bus.
          mem_wren   <= 1'b0;
          wr_ack     <= 1'b0;
          clear_busy <= 1'b1;
          state_reg  <= ST_RUN;
        end
        default: begin
          if (flush) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            mem_wren    <= 1'b0;
            wr_ack      <= 1'b0;
            clear_busy  <= 1'b1;
          end else begin
            clear_busy <= 1'b0;
            wr_ack     <= wr_grant;
            if (vga_grant) begin
              mem_wren <= 1'b0;
              mem_addr <= vga_addr;
            end else if (wr_grant) begin
              mem_wren <= 1'b1;
              mem_addr <= wr_addr;
              mem_d    <= wr_data;
            end else begin
              mem_wren <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Read tag pipeline. Each stage holds a valid bit and a zero flag.
  // The zero flag marks reads that never reached the SRAM, and reads
  // that a restarted clear has abandoned.
  for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_tag
    logic tag_vld_reg;
    logic tag_zero_reg;
    if (gi == 0) begin : g_head
      // A new tag enters on every request.
      // It is flagged zero when the request was not issued to the SRAM.
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_reg  <= 1'b0;
          tag_zero_reg <= 1'b0;
        end else begin
          tag_vld_reg  <= vga_req;
          tag_zero_reg <= !vga_grant;
        end
      end
    end else begin : g_body
      // Tags advance one stage per cycle. A restarting clear poisons their data.
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_reg  <= 1'b0;
          tag_zero_reg <= 1'b0;
        end else begin
          tag_vld_reg  <= g_tag[gi-1].tag_vld_reg;
          tag_zero_reg <= g_tag[gi-1].tag_zero_reg || flush;
        end
      end
    end
  end

  assign last_vld  = g_tag[READ_LAT-1].tag_vld_reg;
  assign last_zero = g_tag[READ_LAT-1].tag_zero_reg;

  // Return stage: capture mem_q for live tags. vga_data holds between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_valid <= 1'b0;
      vga_data  <= '0;
    end else begin
      vga_valid <= last_vld;
      if (last_vld) begin
        vga_data <= (last_zero || flush) ? '0 : mem_q;
      end
    end
  end

`ifdef SRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Counts cycles in which the writer was waiting and nothing was written.
  // The count saturates at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (wr_req && !wr_grant && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter: CLEAR_TOP=16, CLEAR_VALUE=16'hA5A5, READ_LAT=2.
// The SRAM model returns (address + 1), one register after the address.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_clear;
  logic          clear_busy;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_valid;
  logic [DW-1:0] vga_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic [15:0]   stall_cnt;
  logic [DW-1:0] q_reg = '0;

  int checks = 0;
  int errors = 0;

`ifdef SRAM_ARB_STALL_CNT_EN
  localparam int STALL_EXP = 17;
`else
  localparam int STALL_EXP = 0;
`endif

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_TOP(16), .CLEAR_VALUE(16'hA5A5), .READ_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start_clear(start_clear), .clear_busy(clear_busy),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q_reg <= DW'(mem_addr + 19'd1);
  assign mem_q = q_reg;

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          wreq;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d;
    logic          e_ack;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic vr, input int va, input logic wq, input int wa,
                              input int wd, input logic ew, input int ea, input int ed,
                              input logic ek, input logic ev, input int edat);
    vec_t v;
    v.vreq = vr;       v.vaddr = AW'(va);
    v.wreq = wq;       v.waddr = AW'(wa);   v.wdata = DW'(wd);
    v.e_wren = ew;     v.e_addr = AW'(ea);  v.e_d = DW'(ed);
    v.e_ack = ek;      v.e_valid = ev;      v.e_data = DW'(edat);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_wren", 32'(mem_wren), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_d", 32'(mem_d), 0);
    chk("rst_ack", 32'(wr_ack), 0);
    chk("rst_valid", 32'(vga_valid), 0);
    chk("rst_data", 32'(vga_data), 0);
    chk("rst_busy", 32'(clear_busy), 1);
    chk("rst_stall", 32'(stall_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; start_clear = 1'b0; vga_req = 1'b0; vga_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    // Outputs while held in reset.
    step(); step(); step();
    chk_reset_values();
    $display("reset: wren=%0d addr=%0h busy=%0d", mem_wren, mem_addr, clear_busy);

    // Power-up clear: 16 writes, one SWITCH cycle, then busy drops on edge 18.
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("clr_wren", 32'(mem_wren), 1);
      chk("clr_addr", 32'(mem_addr), 32'(n));
      chk("clr_d", 32'(mem_d), 32'hA5A5);
      chk("clr_busy", 32'(clear_busy), 1);
      $display("clear edge %0d: addr=%0h d=%0h", n + 1, mem_addr, mem_d);
    end
    step();
    chk("switch_wren", 32'(mem_wren), 0);
    chk("switch_busy", 32'(clear_busy), 1);
    step();
    chk("run_busy", 32'(clear_busy), 0);
    chk("run_wren", 32'(mem_wren), 0);

    // RUN vectors: fields are vreq, vaddr, wreq, waddr, wdata, then the
    // expected wren, addr, d, ack, valid and data.
    vecs[0]  = mk(1,  5, 0,  0,      0, 0,  5, 'hA5A5, 0, 0,  0);
    vecs[1]  = mk(0,  0, 0,  0,      0, 0,  5, 'hA5A5, 0, 0,  0);
    vecs[2]  = mk(0,  0, 0,  0,      0, 0,  5, 'hA5A5, 0, 1,  6);
    vecs[3]  = mk(0,  0, 0,  0,      0, 0,  5, 'hA5A5, 0, 0,  6);
    vecs[4]  = mk(1, 10, 1,  7, 'h1234, 0, 10, 'hA5A5, 0, 0,  6);
    vecs[5]  = mk(0,  0, 1,  7, 'h1234, 1,  7, 'h1234, 1, 0,  6);
    vecs[6]  = mk(1, 20, 0,  7, 'h1234, 0, 20, 'h1234, 0, 1, 11);
    vecs[7]  = mk(0,  0, 1, 30, 'h1111, 1, 30, 'h1111, 1, 0, 11);
    vecs[8]  = mk(0,  0, 1, 30, 'h1111, 0, 30, 'h1111, 0, 1, 21);
    vecs[9]  = mk(0,  0, 1, 31, 'h2222, 1, 31, 'h2222, 1, 0, 21);
    vecs[10] = mk(0,  0, 1, 31, 'h2222, 0, 31, 'h2222, 0, 0, 21);
    vecs[11] = mk(0,  0, 1, 32, 'h3333, 1, 32, 'h3333, 1, 0, 21);
    vecs[12] = mk(0,  0, 1, 32, 'h3333, 0, 32, 'h3333, 0, 0, 21);
    vecs[13] = mk(0,  0, 1, 33, 'h4444, 1, 33, 'h4444, 1, 0, 21);
    vecs[14] = mk(0,  0, 0, 33, 'h4444, 0, 33, 'h4444, 0, 0, 21);

    for (int i = 0; i < 15; i++) begin
      vga_req = vecs[i].vreq; vga_addr = vecs[i].vaddr;
      wr_req = vecs[i].wreq;  wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
      step();
      chk($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(vecs[i].e_wren));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_d", i), 32'(mem_d), 32'(vecs[i].e_d));
      chk($sformatf("v%0d_ack", i), 32'(wr_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_valid", i), 32'(vga_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_data", i), 32'(vga_data), 32'(vecs[i].e_data));
      $display("vec %0d: wren=%0d addr=%0h d=%0h ack=%0d valid=%0d data=%0h",
               i, mem_wren, mem_addr, mem_d, wr_ack, vga_valid, vga_data);
    end

    // start_clear with a read in flight and a write pending.
    vga_req = 1'b1; vga_addr = 19'd40; wr_req = 1'b0;
    step();
    chk("sc_grant_addr", 32'(mem_addr), 40);
    vga_req = 1'b0; start_clear = 1'b1;
    wr_req = 1'b1; wr_addr = 19'd50; wr_data = 16'h5555;
    step();
    chk("sc_busy", 32'(clear_busy), 1);
    chk("sc_wren", 32'(mem_wren), 0);
    chk("sc_ack", 32'(wr_ack), 0);
    start_clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vga_req = (i == 4);
      step();
      chk("rc_wren", 32'(mem_wren), 1);
      chk("rc_addr", 32'(mem_addr), 32'(i));
      chk("rc_ack", 32'(wr_ack), 0);
      chk("rc_busy", 32'(clear_busy), 1);
      chk("rc_valid", 32'(vga_valid), 32'((i == 0) || (i == 6)));
      if (i == 0 || i == 6) chk("rc_data_zero", 32'(vga_data), 0);
      $display("reclear edge %0d: addr=%0h valid=%0d data=%0h", i, mem_addr, vga_valid, vga_data);
    end
    vga_req = 1'b0;
    step();
    chk("rc_switch_wren", 32'(mem_wren), 0);
    chk("rc_switch_ack", 32'(wr_ack), 0);
    step();
    chk("rc_busy_low", 32'(clear_busy), 0);
    chk("rc_first_ack", 32'(wr_ack), 1);
    chk("rc_wr_addr", 32'(mem_addr), 50);
    chk("rc_wr_d", 32'(mem_d), 32'h5555);
    wr_req = 1'b0;
    step();
    chk("rc_ack_pulse", 32'(wr_ack), 0);

    // Writer stalled across a power-up clear, then reset in the middle of a clear.
    rst = 1'b1;
    step(); step();
    chk_reset_values();
    rst = 1'b0; wr_req = 1'b1; wr_addr = 19'd60; wr_data = 16'h6666;
    for (int n = 1; n <= 17; n++) begin
      step();
      chk("stall_no_ack", 32'(wr_ack), 0);
    end
    chk("stall_before_ack", 32'(stall_cnt), 32'(STALL_EXP));
    step();
    chk("stall_ack", 32'(wr_ack), 1);
    chk("stall_ack_addr", 32'(mem_addr), 60);
    chk("stall_at_ack", 32'(stall_cnt), 32'(STALL_EXP));
    $display("stall: ack=%0d stall_cnt=%0d", wr_ack, stall_cnt);
    wr_req = 1'b0; start_clear = 1'b1;
    step();
    chk("mc_busy", 32'(clear_busy), 1);
    start_clear = 1'b0; vga_req = 1'b1;
    step();
    chk("mc_addr0", 32'(mem_addr), 0);
    vga_req = 1'b0;
    step();
    chk("mc_addr1", 32'(mem_addr), 1);
    rst = 1'b1;
    step();
    chk_reset_values();
    step();
    chk("mc_valid_flushed", 32'(vga_valid), 0);
    rst = 1'b0;
    step();
    chk("mc_restart_wren", 32'(mem_wren), 1);
    chk("mc_restart_addr", 32'(mem_addr), 0);
    step();
    chk("mc_restart_addr1", 32'(mem_addr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
